// File: rtl/msrh_br_upd_receiver.sv
// Branch-tag pool: allocates tags to dispatched branches, tracks dependencies,
// frees tags on correct resolve and squashes dependents plus redirects on mispredict.
module msrh_br_upd_receiver #(
  parameter int BRTAG_SIZE = 8,
  parameter int VADDR_W    = 39,
  parameter int CMT_ID_W   = 6,
  parameter int GRP_W      = 5,
  localparam int TAG_W     = $clog2(BRTAG_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_alloc_req,
  output logic                  o_alloc_ready,
  output logic [TAG_W-1:0]      o_alloc_tag,
  output logic [BRTAG_SIZE-1:0] o_alloc_brmask,
  input  logic                  i_upd_valid,
  input  logic [TAG_W-1:0]      i_upd_tag,
  input  logic                  i_upd_mispredict,
  input  logic [VADDR_W-1:0]    i_upd_target_vaddr,
  input  logic [CMT_ID_W-1:0]   i_upd_cmt_id,
  input  logic [GRP_W-1:0]      i_upd_grp_id,
  input  logic                  i_flush_all,
  output logic [BRTAG_SIZE-1:0] o_valid_mask,
  output logic [BRTAG_SIZE-1:0] o_resolve_mask,
  output logic [BRTAG_SIZE-1:0] o_kill_mask,
  output logic                  o_redirect_valid,
  output logic [VADDR_W-1:0]    o_redirect_vaddr,
  output logic [CMT_ID_W-1:0]   o_redirect_cmt_id,
  output logic [GRP_W-1:0]      o_redirect_grp_id
);

  localparam logic [BRTAG_SIZE-1:0] ONE = {{(BRTAG_SIZE-1){1'b0}}, 1'b1};

  logic [BRTAG_SIZE-1:0]                  valid_q, valid_d;
  logic [BRTAG_SIZE-1:0][BRTAG_SIZE-1:0]  dep_q, dep_d;
  logic [BRTAG_SIZE-1:0]                  resolve_q, resolve_d;
  logic [BRTAG_SIZE-1:0]                  kill_q, kill_d;
  logic                                   redir_vld_q, redir_vld_d;
  logic [VADDR_W-1:0]                     redir_vaddr_q, redir_vaddr_d;
  logic [CMT_ID_W-1:0]                    redir_cmt_q, redir_cmt_d;
  logic [GRP_W-1:0]                       redir_grp_q, redir_grp_d;

  logic [TAG_W-1:0]      free_tag;
  logic                  grant, upd_hit, mispred;
  logic [BRTAG_SIZE-1:0] upd_oh, alloc_oh, res_oh;

  always_comb begin
    free_tag = '0;
    for (int i = BRTAG_SIZE-1; i >= 0; i--) begin
      if (!valid_q[i]) free_tag = TAG_W'(i);
    end
  end

  assign o_alloc_ready  = ~&valid_q;
  assign o_alloc_tag    = free_tag;
  assign o_alloc_brmask = valid_q;

  always_comb begin
    grant    = i_alloc_req && o_alloc_ready && !i_flush_all;
    upd_hit  = i_upd_valid && valid_q[i_upd_tag] && !i_flush_all;
    mispred  = upd_hit && i_upd_mispredict;
    upd_oh   = ONE << i_upd_tag;
    alloc_oh = ONE << free_tag;
    res_oh   = (upd_hit && !i_upd_mispredict) ? upd_oh : '0;

    // Kill set: the mispredicted tag, every live tag that depends on it, and
    // a tag being granted this very cycle (it necessarily depends on it too).
    kill_d = '0;
    if (mispred) begin
      kill_d = upd_oh;
      for (int u = 0; u < BRTAG_SIZE; u++) begin
        if (valid_q[u] && dep_q[u][i_upd_tag]) kill_d[u] = 1'b1;
      end
      if (grant) kill_d = kill_d | alloc_oh;
    end

    valid_d = valid_q & ~res_oh & ~kill_d;
    if (grant) valid_d = valid_d | (alloc_oh & ~kill_d);

    // Freed/killed columns are scrubbed so a reused tag never inherits stale dependents.
    dep_d = dep_q;
    for (int r = 0; r < BRTAG_SIZE; r++) dep_d[r] = dep_q[r] & ~res_oh & ~kill_d;
    if (grant) dep_d[free_tag] = valid_q & ~res_oh;

    resolve_d     = res_oh;
    redir_vld_d   = mispred;
    redir_vaddr_d = mispred ? i_upd_target_vaddr : redir_vaddr_q;
    redir_cmt_d   = mispred ? i_upd_cmt_id       : redir_cmt_q;
    redir_grp_d   = mispred ? i_upd_grp_id       : redir_grp_q;

    if (i_flush_all) begin
      valid_d   = '0;
      dep_d     = '0;
      kill_d    = '0;
      resolve_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q       <= '0;
      dep_q         <= '0;
      resolve_q     <= '0;
      kill_q        <= '0;
      redir_vld_q   <= 1'b0;
      redir_vaddr_q <= '0;
      redir_cmt_q   <= '0;
      redir_grp_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      dep_q         <= dep_d;
      resolve_q     <= resolve_d;
      kill_q        <= kill_d;
      redir_vld_q   <= redir_vld_d;
      redir_vaddr_q <= redir_vaddr_d;
      redir_cmt_q   <= redir_cmt_d;
      redir_grp_q   <= redir_grp_d;
    end
  end

  assign o_valid_mask      = valid_q;
  assign o_resolve_mask    = resolve_q;
  assign o_kill_mask       = kill_q;
  assign o_redirect_valid  = redir_vld_q;
  assign o_redirect_vaddr  = redir_vaddr_q;
  assign o_redirect_cmt_id = redir_cmt_q;
  assign o_redirect_grp_id = redir_grp_q;

endmodule

// File: tb/tb_msrh_br_upd_receiver.sv
// Directed bench for msrh_br_upd_receiver with hand-computed expectations.
module tb_msrh_br_upd_receiver;

  localparam int BRTAG_SIZE = 8;
  localparam int VADDR_W    = 39;
  localparam int CMT_ID_W   = 6;
  localparam int GRP_W      = 5;
  localparam int TAG_W      = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  alloc_req = 1'b0;
  logic                  alloc_ready;
  logic [TAG_W-1:0]      alloc_tag;
  logic [BRTAG_SIZE-1:0] alloc_brmask;
  logic                  upd_valid = 1'b0;
  logic [TAG_W-1:0]      upd_tag = '0;
  logic                  upd_misp = 1'b0;
  logic [VADDR_W-1:0]    upd_vaddr = '0;
  logic [CMT_ID_W-1:0]   upd_cmt = '0;
  logic [GRP_W-1:0]      upd_grp = '0;
  logic                  flush_all = 1'b0;
  logic [BRTAG_SIZE-1:0] valid_mask, resolve_mask, kill_mask;
  logic                  redir_valid;
  logic [VADDR_W-1:0]    redir_vaddr;
  logic [CMT_ID_W-1:0]   redir_cmt;
  logic [GRP_W-1:0]      redir_grp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msrh_br_upd_receiver #(
    .BRTAG_SIZE(BRTAG_SIZE), .VADDR_W(VADDR_W), .CMT_ID_W(CMT_ID_W), .GRP_W(GRP_W)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_alloc_req(alloc_req), .o_alloc_ready(alloc_ready),
    .o_alloc_tag(alloc_tag), .o_alloc_brmask(alloc_brmask),
    .i_upd_valid(upd_valid), .i_upd_tag(upd_tag), .i_upd_mispredict(upd_misp),
    .i_upd_target_vaddr(upd_vaddr), .i_upd_cmt_id(upd_cmt), .i_upd_grp_id(upd_grp),
    .i_flush_all(flush_all),
    .o_valid_mask(valid_mask), .o_resolve_mask(resolve_mask), .o_kill_mask(kill_mask),
    .o_redirect_valid(redir_valid), .o_redirect_vaddr(redir_vaddr),
    .o_redirect_cmt_id(redir_cmt), .o_redirect_grp_id(redir_grp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [TAG_W-1:0] t, input logic m, input logic [VADDR_W-1:0] va,
                     input logic [CMT_ID_W-1:0] c, input logic [GRP_W-1:0] g);
    upd_valid = 1'b1; upd_tag = t; upd_misp = m; upd_vaddr = va; upd_cmt = c; upd_grp = g;
  endtask

  task automatic idle();
    upd_valid = 1'b0; upd_misp = 1'b0; alloc_req = 1'b0; flush_all = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_req = 1'b1;
    for (int i = 0; i < n; i++) tick();
    alloc_req = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_valid", valid_mask, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_tag", alloc_tag, 0);
    check("rst_kill", kill_mask, 0);
    check("rst_resolve", resolve_mask, 0);
    check("rst_redir", redir_valid, 0);
    check("rst_vaddr", redir_vaddr, 0);
    rst = 1'b0;
    tick();

    // Fill all eight tags in order.
    alloc_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_tag%0d", i), alloc_tag, i);
      check($sformatf("fill_brmask%0d", i), alloc_brmask, (64'd1 << i) - 1);
      tick();
    end
    check("full_valid", valid_mask, 8'hFF);
    check("full_ready", alloc_ready, 0);
    tick();
    alloc_req = 1'b0;
    check("ninth_valid", valid_mask, 8'hFF);

    // Correct resolve of tag 3, then reuse it.
    upd(3, 0, '0, '0, '0);
    tick();
    idle();
    check("res3_mask", resolve_mask, 8'h08);
    check("res3_valid", valid_mask, 8'hF7);
    check("res3_kill", kill_mask, 0);
    check("res3_redir", redir_valid, 0);
    alloc_req = 1'b1;
    check("reuse_tag", alloc_tag, 3);
    check("reuse_brmask", alloc_brmask, 8'hF7);
    tick();
    alloc_req = 1'b0;
    check("reuse_valid", valid_mask, 8'hFF);
    check("res_pulse_end", resolve_mask, 0);

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #2;
    check("async_rst_valid", valid_mask, 0);
    check("async_rst_ready", alloc_ready, 1);
    rst = 1'b0;
    tick();

    // Mispredict tag 1 with tags 0..3 live.
    alloc_n(4);
    check("four_valid", valid_mask, 8'h0F);
    upd(1, 1, 39'h80001000, 6'd5, 5'h04);
    tick();
    idle();
    check("mp1_kill", kill_mask, 8'h0E);
    check("mp1_valid", valid_mask, 8'h01);
    check("mp1_redir", redir_valid, 1);
    check("mp1_vaddr", redir_vaddr, 39'h80001000);
    check("mp1_cmt", redir_cmt, 5);
    check("mp1_grp", redir_grp, 5'h04);
    tick();
    check("mp1_redir_end", redir_valid, 0);
    check("mp1_kill_end", kill_mask, 0);

    // Stale mispredict on already-killed tag 2.
    upd(2, 1, 39'h1234, 6'd9, 5'h01);
    tick();
    idle();
    check("stale_kill", kill_mask, 0);
    check("stale_redir", redir_valid, 0);
    check("stale_valid", valid_mask, 8'h01);

    // Allocation racing a mispredict on tag 0.
    alloc_req = 1'b1;
    check("race_pre_tag", alloc_tag, 1);
    tick();
    check("race_pre_valid", valid_mask, 8'h03);
    upd(0, 1, 39'h4000, 6'd2, 5'h02);
    check("race_tag", alloc_tag, 2);
    tick();
    idle();
    check("race_kill", kill_mask, 8'h07);
    check("race_valid", valid_mask, 0);
    check("race_redir", redir_valid, 1);

    // Allocation alongside a correct resolve; resolved column must be dropped.
    alloc_n(2);
    alloc_req = 1'b1;
    upd(0, 0, '0, '0, '0);
    check("ar_tag", alloc_tag, 2);
    check("ar_brmask", alloc_brmask, 8'h03);
    tick();
    idle();
    check("ar_valid", valid_mask, 8'h06);
    check("ar_resolve", resolve_mask, 8'h01);
    alloc_req = 1'b1;
    check("ar_reuse_tag", alloc_tag, 0);
    check("ar_reuse_brmask", alloc_brmask, 8'h06);
    tick();
    alloc_req = 1'b0;
    check("ar_reuse_valid", valid_mask, 8'h07);
    upd(0, 1, 39'h10, 6'd1, 5'h01);
    tick();
    idle();
    check("ar_mp0_kill", kill_mask, 8'h01);
    check("ar_mp0_valid", valid_mask, 8'h06);
    upd(1, 1, 39'h20, 6'd3, 5'h08);
    tick();
    idle();
    check("ar_mp1_kill", kill_mask, 8'h06);
    check("ar_mp1_valid", valid_mask, 0);

    // Back-to-back resolves.
    alloc_n(3);
    upd(0, 0, '0, '0, '0);
    tick();
    check("b2b_res0", resolve_mask, 8'h01);
    upd(1, 0, '0, '0, '0);
    tick();
    idle();
    check("b2b_res1", resolve_mask, 8'h02);
    check("b2b_valid", valid_mask, 8'h04);
    tick();
    check("b2b_res_end", resolve_mask, 0);

    // Flush dominates a simultaneous mispredict and alloc.
    alloc_n(4);
    check("pre_flush_valid", valid_mask, 8'h1F);
    flush_all = 1'b1;
    alloc_req = 1'b1;
    upd(1, 1, 39'h999, 6'd7, 5'h10);
    tick();
    idle();
    check("flush_valid", valid_mask, 0);
    check("flush_kill", kill_mask, 0);
    check("flush_redir", redir_valid, 0);
    check("flush_resolve", resolve_mask, 0);
    check("flush_next_tag", alloc_tag, 0);
    check("flush_ready", alloc_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
